// File: rtl/ram_nway.sv
// Parametrised RAM of 2^ADDR_W words with an optional registered read port and a
// background clear sweep that zeroes one word per cycle while busy is high.
module ram_nway #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int REG_OUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              busy_reg;
  logic [WIDTH-1:0]  mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          // The last word is cleared on this edge, so the pointer never wraps.
          if (ptr_reg == '1) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ptr_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Full reset of the storage rules out block RAM; every word is a register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_reg[i] <= '0;
      end else if (state_reg == CLEAR && ptr_reg == ADDR_W'(i)) begin
        mem_reg[i] <= '0;
      end else if (state_reg == IDLE && load && address == ADDR_W'(i)) begin
        mem_reg[i] <= in;
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_read
      logic [WIDTH-1:0] out_reg;
      // Samples the pre-write contents, giving read-before-write on a shared address.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_reg <= '0;
        end else begin
          out_reg <= mem_reg[address];
        end
      end
      assign out = out_reg;
    end else begin : g_comb_read
      assign out = mem_reg[address];
    end
  endgenerate

  assign busy = busy_reg;

endmodule
